// File: rtl/crc8_frame_checker.sv
// Receive-side CRC-8 frame checker: strips the trailing CRC byte, forwards the payload one byte late,
// and reports CRC/length status at end of frame. No backpressure; every valid byte is accepted.
module crc8_frame_checker #(
  parameter logic [7:0]  POLYNOMIAL = 8'h07,
  parameter logic [7:0]  INITIAL    = 8'h00,
  parameter int unsigned MAX_LEN    = 255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] data_i,
  input  logic       data_valid_i,
  input  logic       data_last_i,
  output logic [7:0] data_o,
  output logic       data_valid_o,
  output logic       data_last_o,
  output logic       frame_done_o,
  output logic       frame_ok_o,
  output logic       crc_err_o,
  output logic       len_err_o,
  output logic [7:0] frame_len_o,
  output logic [7:0] crc_o
);

  localparam logic [8:0] MAX_LEN_9 = 9'(MAX_LEN);
  localparam logic [7:0] MAX_LEN_8 = 8'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, HOLD, DROP} state_t;

  function automatic logic [7:0] crc_next(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ({r[6:0], 1'b0} ^ POLYNOMIAL) : {r[6:0], 1'b0};
    end
    return r;
  endfunction

  state_t     r_state, w_state;
  logic [7:0] r_held, w_held;
  logic [7:0] r_crc, w_crc;
  logic [7:0] r_count, w_count;
  logic [7:0] r_data, w_data;
  logic       r_data_vld, w_data_vld;
  logic       r_data_last, w_data_last;
  logic       r_done, w_done;
  logic       r_ok, w_ok;
  logic       r_crc_err, w_crc_err;
  logic       r_len_err, w_len_err;
  logic [7:0] r_len, w_len;
  logic [7:0] r_crc_out, w_crc_out;

  logic [7:0] w_fold;
  logic [8:0] w_count_inc;
  logic       w_overflow;

  assign w_fold      = crc_next(r_crc, r_held);
  assign w_count_inc = {1'b0, r_count} + 9'd1;
  assign w_overflow  = w_count_inc > MAX_LEN_9;

  always_comb begin
    w_state     = r_state;
    w_held      = r_held;
    w_crc       = r_crc;
    w_count     = r_count;
    w_data      = r_data;
    w_data_vld  = 1'b0;
    w_data_last = 1'b0;
    w_done      = 1'b0;
    w_ok        = r_ok;
    w_crc_err   = r_crc_err;
    w_len_err   = r_len_err;
    w_len       = r_len;
    w_crc_out   = r_crc_out;

    if (data_valid_i) begin
      unique case (r_state)
        IDLE: begin
          if (data_last_i) begin
            w_done    = 1'b1;
            w_ok      = 1'b0;
            w_crc_err = 1'b0;
            w_len_err = 1'b1;
            w_len     = 8'd0;
          end else begin
            w_held  = data_i;
            w_state = HOLD;
          end
        end
        HOLD: begin
          if (w_overflow) begin
            // Held byte would exceed the length limit: drop it and the rest of the frame.
            if (data_last_i) begin
              w_done    = 1'b1;
              w_ok      = 1'b0;
              w_crc_err = 1'b0;
              w_len_err = 1'b1;
              w_len     = MAX_LEN_8;
              w_crc     = INITIAL;
              w_count   = 8'd0;
              w_state   = IDLE;
            end else begin
              w_state = DROP;
            end
          end else begin
            w_data     = r_held;
            w_data_vld = 1'b1;
            w_crc_out  = w_fold;
            w_crc      = w_fold;
            w_count    = w_count_inc[7:0];
            w_held     = data_i;
            if (data_last_i) begin
              w_data_last = 1'b1;
              w_done      = 1'b1;
              w_ok        = (w_fold == data_i);
              w_crc_err   = (w_fold != data_i);
              w_len_err   = 1'b0;
              w_len       = w_count_inc[7:0];
              w_crc       = INITIAL;
              w_count     = 8'd0;
              w_state     = IDLE;
            end
          end
        end
        DROP: begin
          if (data_last_i) begin
            w_done    = 1'b1;
            w_ok      = 1'b0;
            w_crc_err = 1'b0;
            w_len_err = 1'b1;
            w_len     = MAX_LEN_8;
            w_crc     = INITIAL;
            w_count   = 8'd0;
            w_state   = IDLE;
          end
        end
        default: w_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_held      <= 8'd0;
      r_crc       <= INITIAL;
      r_count     <= 8'd0;
      r_data      <= 8'd0;
      r_data_vld  <= 1'b0;
      r_data_last <= 1'b0;
      r_done      <= 1'b0;
      r_ok        <= 1'b0;
      r_crc_err   <= 1'b0;
      r_len_err   <= 1'b0;
      r_len       <= 8'd0;
      r_crc_out   <= INITIAL;
    end else begin
      r_state     <= w_state;
      r_held      <= w_held;
      r_crc       <= w_crc;
      r_count     <= w_count;
      r_data      <= w_data;
      r_data_vld  <= w_data_vld;
      r_data_last <= w_data_last;
      r_done      <= w_done;
      r_ok        <= w_ok;
      r_crc_err   <= w_crc_err;
      r_len_err   <= w_len_err;
      r_len       <= w_len;
      r_crc_out   <= w_crc_out;
    end
  end

  assign data_o       = r_data;
  assign data_valid_o = r_data_vld;
  assign data_last_o  = r_data_last;
  assign frame_done_o = r_done;
  assign frame_ok_o   = r_ok;
  assign crc_err_o    = r_crc_err;
  assign len_err_o    = r_len_err;
  assign frame_len_o  = r_len;
  assign crc_o        = r_crc_out;

endmodule

// File: tb/tb_crc8_frame_checker.sv
// Bench for crc8_frame_checker: two instances (MAX_LEN 255 and 4) share one input stream and are
// compared against a frame-level model using polynomial long division for the CRC.
module tb_crc8_frame_checker;

  typedef struct packed {
    logic       ok;
    logic       cerr;
    logic       lerr;
    logic [7:0] len;
    logic [7:0] crc;
  } stat_t;
  typedef logic [7:0]  bq_t[$];
  typedef logic [31:0] wq_t[$];

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       dvld, dlast;

  logic [7:0] a_do, a_len, a_crc, b_do, b_len, b_crc;
  logic       a_dvo, a_dlo, a_done, a_ok, a_cerr, a_lerr;
  logic       b_dvo, b_dlo, b_done, b_ok, b_cerr, b_lerr;

  int n_pass = 0;
  int n_total = 0;

  wq_t ob_a, ob_b, eb_a, eb_b, os_a, os_b, es_a, es_b;
  stat_t last_a, last_b;

  always #5 clk = ~clk;

  crc8_frame_checker #(.MAX_LEN(255)) dut_a (
    .clk_i(clk), .rst_i(rst), .data_i(din), .data_valid_i(dvld), .data_last_i(dlast),
    .data_o(a_do), .data_valid_o(a_dvo), .data_last_o(a_dlo), .frame_done_o(a_done),
    .frame_ok_o(a_ok), .crc_err_o(a_cerr), .len_err_o(a_lerr), .frame_len_o(a_len), .crc_o(a_crc)
  );

  crc8_frame_checker #(.MAX_LEN(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .data_i(din), .data_valid_i(dvld), .data_last_i(dlast),
    .data_o(b_do), .data_valid_o(b_dvo), .data_last_o(b_dlo), .frame_done_o(b_done),
    .frame_ok_o(b_ok), .crc_err_o(b_cerr), .len_err_o(b_lerr), .frame_len_o(b_len), .crc_o(b_crc)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (a_dvo || a_dlo) ob_a.push_back(32'({a_dlo, a_do}));
      if (b_dvo || b_dlo) ob_b.push_back(32'({b_dlo, b_do}));
      if (a_done) os_a.push_back(32'({a_ok, a_cerr, a_lerr, a_len, a_crc}));
      if (b_done) os_b.push_back(32'({b_ok, b_cerr, b_lerr, b_len, b_crc}));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Remainder of M(x)*x^8 divided by x^8+x^2+x+1, message taken MSB-first.
  function automatic logic [7:0] ref_crc(input bq_t m, input int n);
    logic [8:0] rem;
    logic       b;
    rem = 9'd0;
    for (int i = 0; i < n * 8 + 8; i++) begin
      b = (i < n * 8) ? m[i / 8][7 - (i % 8)] : 1'b0;
      rem = {rem[7:0], b};
      if (rem[8]) rem = rem ^ 9'h107;
    end
    return rem[7:0];
  endfunction

  function automatic bq_t mk(input int n, input bit corrupt);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    q.push_back(ref_crc(q, n) ^ {7'd0, corrupt});
    return q;
  endfunction

  task automatic model(input int inst, input bq_t fr);
    int    mx, n, k;
    stat_t s;
    logic [7:0] c, prev;
    logic [31:0] e;
    mx = (inst == 0) ? 255 : 4;
    n = fr.size() - 1;
    prev = (inst == 0) ? last_a.crc : last_b.crc;
    if (n == 0) begin
      s = '{1'b0, 1'b0, 1'b1, 8'd0, prev};
    end else begin
      k = (n > mx) ? mx : n;
      c = ref_crc(fr, k);
      for (int i = 0; i < k; i++) begin
        e = 32'({(n <= mx) && (i == k - 1), fr[i]});
        if (inst == 0) eb_a.push_back(e); else eb_b.push_back(e);
      end
      if (n > mx) s = '{1'b0, 1'b0, 1'b1, 8'(mx), c};
      else        s = '{c == fr[n], c != fr[n], 1'b0, 8'(n), c};
    end
    if (inst == 0) begin es_a.push_back(32'(s)); last_a = s; end
    else begin es_b.push_back(32'(s)); last_b = s; end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    dvld = 1'b0;
    din = 8'($urandom);
    dlast = 1'($urandom);
  endtask

  task automatic send(input bq_t fr, input int maxgap, input bit with_last);
    int g;
    for (int i = 0; i < fr.size(); i++) begin
      g = int'($urandom_range(maxgap, 0));
      repeat (g) idle();
      @(posedge clk); #1;
      din = fr[i];
      dvld = 1'b1;
      dlast = with_last && (i == fr.size() - 1);
    end
  endtask

  task automatic frame(input bq_t fr, input int maxgap);
    model(0, fr);
    model(1, fr);
    send(fr, maxgap, 1'b1);
  endtask

  task automatic check_q(input string tag, input wq_t o, input wq_t e);
    chk({tag, "_count"}, o.size(), e.size());
    for (int i = 0; i < o.size() && i < e.size(); i++) chk(tag, o[i], e[i]);
  endtask

  task automatic check_all(input string tag);
    repeat (3) idle();
    check_q({tag, "_a_bytes"}, ob_a, eb_a);
    check_q({tag, "_b_bytes"}, ob_b, eb_b);
    check_q({tag, "_a_status"}, os_a, es_a);
    check_q({tag, "_b_status"}, os_b, es_b);
    chk({tag, "_a_levels"}, 32'({a_ok, a_cerr, a_lerr, a_len, a_crc}), 32'(last_a));
    chk({tag, "_b_levels"}, 32'({b_ok, b_cerr, b_lerr, b_len, b_crc}), 32'(last_b));
    ob_a.delete(); ob_b.delete(); eb_a.delete(); eb_b.delete();
    os_a.delete(); os_b.delete(); es_a.delete(); es_b.delete();
  endtask

  initial begin
    bq_t fr;
    rst = 1'b1; dvld = 1'b0; dlast = 1'b0; din = 8'd0;
    last_a = '0; last_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_a", 32'({a_do, a_dvo, a_dlo, a_done, a_ok, a_cerr, a_lerr, a_len, a_crc}), 32'd0);
    chk("reset_b", 32'({b_do, b_dvo, b_dlo, b_done, b_ok, b_cerr, b_lerr, b_len, b_crc}), 32'd0);

    fr = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hF4};
    frame(fr, 0);
    check_all("good");
    chk("good_crc", 32'(a_crc), 32'h0000_00F4);
    chk("good_ok_len", 32'({a_ok, a_len}), 32'h0000_0109);

    fr[9] = 8'hF5;
    frame(fr, 0);
    check_all("badcrc");
    chk("badcrc_flags", 32'({a_ok, a_cerr, a_lerr}), 32'd2);

    fr = '{8'h00};
    frame(fr, 0);
    check_all("runt");

    frame(mk(6, 1'b0), 0);
    check_all("overflow6");
    frame(mk(3, 1'b0), 0);
    check_all("after_ovf");
    frame(mk(4, 1'b0), 0);
    check_all("exact_max");
    frame(mk(5, 1'b0), 0);
    check_all("max_plus1");

    for (int i = 0; i < 6; i++) begin
      frame(mk(int'($urandom_range(12, 0)), 1'($urandom_range(3, 0) == 0)), 5);
      check_all("gaps");
    end
    fr = mk(3, 1'b0);
    frame(fr, 5);
    frame(fr, 0);
    check_all("b2b");

    fr = mk(6, 1'b0);
    send(fr[0:2], 2, 1'b0);
    eb_a.push_back(32'({1'b0, fr[0]})); eb_a.push_back(32'({1'b0, fr[1]}));
    eb_b.push_back(32'({1'b0, fr[0]})); eb_b.push_back(32'({1'b0, fr[1]}));
    idle();
    @(posedge clk); #1 rst = 1'b1;
    #1;
    chk("midrst_a", 32'({a_do, a_dvo, a_dlo, a_done, a_ok, a_cerr, a_lerr, a_len, a_crc}), 32'd0);
    chk("midrst_b", 32'({b_do, b_dvo, b_dlo, b_done, b_ok, b_cerr, b_lerr, b_len, b_crc}), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    last_a = '0; last_b = '0;
    check_all("aborted");
    frame(mk(4, 1'b0), 1);
    check_all("after_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
